// File: rtl/fp_div_pkg.sv
// Shared single-precision FP definitions: field widths, rounding modes, special values.
// Latency: n/a (types, constants and a combinational classifier only).
// Backpressure: n/a.
package fp_div_pkg;

  localparam int W  = 32;     // total word width
  localparam int M  = 22;     // MSB index of fraction field
  localparam int E  = 30;     // MSB index of exponent field
  localparam int QB = 26;     // quotient bits: 1 integer + 23 fraction + guard + round
  localparam int MW = M + 2;  // mantissa width including the hidden one

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RZ  = 3'b001,
    RD  = 3'b010,
    RU  = 3'b011,
    RMM = 3'b100
  } round_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPEC,
    S_DIV,
    S_ROUND
  } div_state_t;

  typedef struct packed {
    logic           sign;
    logic [E-M-1:0] exp;
    logic [M:0]     frac;
  } fp_t;

  typedef struct packed {
    logic zero;   // exponent 0; subnormals are flushed and count as zero
    logic inf;
    logic nan;
    logic snan;
  } fp_class_t;

  localparam logic [W-1:0] FP_ZEROP = 32'h0000_0000;
  localparam logic [W-1:0] FP_ZERON = 32'h8000_0000;
  localparam logic [W-1:0] FP_INFP  = 32'h7F80_0000;
  localparam logic [W-1:0] FP_INFN  = 32'hFF80_0000;
  localparam logic [W-1:0] FP_NANQ  = 32'h7FC0_0000;
  localparam logic [W-1:0] FP_NANS  = 32'h7FA0_0000;
  localparam logic [W-1:0] FP_MAXP  = 32'h7F7F_FFFF;
  localparam logic [W-1:0] FP_MAXN  = 32'hFF7F_FFFF;

  function automatic fp_class_t fp_classify(input fp_t x);
    fp_class_t c;
    c.zero = (x.exp == '0);
    c.inf  = (x.exp == '1) && (x.frac == '0);
    c.nan  = (x.exp == '1) && (x.frac != '0);
    c.snan = c.nan && !x.frac[M];
    return c;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Rounds a normalised quotient/product mantissa to single precision, with overflow/underflow.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module fp_round
  import fp_div_pkg::*;
(
  input  logic               sign,
  input  logic signed [9:0]  exp,
  input  logic [QB-1:0]      q,
  input  logic               sticky,
  input  logic [2:0]         mode,
  output logic [W-1:0]       res,
  output logic               ov,
  output logic               un,
  output logic               inexact
);

  logic              l_bit;
  logic              g_bit;
  logic              t_bit;
  logic              inc;
  logic [MW:0]       sum;
  logic signed [9:0] exp_r;
  logic [M:0]        frac;

  // Select increment by mode, renormalise on carry-out, then clamp the exponent range.
  always_comb begin
    l_bit = q[2];
    g_bit = q[1];
    t_bit = q[0] | sticky;
    case (mode)
      RNE:     inc = g_bit & (t_bit | l_bit);
      RD:      inc = sign & (g_bit | t_bit);
      RU:      inc = !sign & (g_bit | t_bit);
      RMM:     inc = g_bit;
      default: inc = 1'b0;  // RZ and unused codes truncate
    endcase
    sum     = {1'b0, q[QB-1:2]} + {{MW{1'b0}}, inc};
    exp_r   = exp + (sum[MW] ? 10'sd1 : 10'sd0);
    frac    = sum[MW] ? sum[MW-1:1] : sum[MW-2:0];
    res     = {sign, exp_r[7:0], frac};
    ov      = 1'b0;
    un      = 1'b0;
    inexact = g_bit | t_bit;
    if (exp_r > 10'sd254) begin
      ov      = 1'b1;
      inexact = 1'b1;
      case (mode)
        RNE, RMM: res = sign ? FP_INFN : FP_INFP;
        RD:       res = sign ? FP_INFN : FP_MAXP;
        RU:       res = sign ? FP_MAXN : FP_INFP;
        default:  res = sign ? FP_MAXN : FP_MAXP;
      endcase
    end else if (exp_r < 10'sd1) begin
      un      = 1'b1;
      inexact = 1'b1;
      res     = sign ? FP_ZERON : FP_ZEROP;
    end
  end

endmodule

// File: rtl/fp_div.sv
// Iterative single-precision divider out = in1 / in2, one restoring quotient bit per cycle.
// Latency: done 2 edges after accept for special operands, 28 edges for normal results.
// Backpressure: start is ignored while busy; no output stall, result held until next done.
module fp_div
  import fp_div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         busy,
  output logic         done,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact,
  output logic         dz
);

  div_state_t        state_q;
  div_state_t        state_d;
  fp_t               a_q;
  fp_t               b_q;
  logic [2:0]        rm_q;
  logic              sign_q;
  logic signed [9:0] eq_q;
  logic [MW:0]       rem_q;
  logic [MW-1:0]     dvs_q;
  logic [QB-1:0]     q_q;
  logic [4:0]        cnt_q;
  logic              spec_q;
  logic [W-1:0]      spec_res_q;
  logic              spec_inv_q;
  logic              spec_dz_q;

  fp_class_t         ca;
  fp_class_t         cb;
  logic              sign_nx;
  logic              spec_hit;
  logic              spec_inv;
  logic              spec_dz;
  logic [W-1:0]      spec_res;
  logic [MW-1:0]     ma;
  logic [MW-1:0]     mb;
  logic              lt;
  logic [MW:0]       rem_init;
  logic signed [9:0] eq_nx;
  logic              ge;
  logic [MW:0]       diff;
  logic [MW:0]       rem_step;

  logic [W-1:0]      rnd_res;
  logic              rnd_ov;
  logic              rnd_un;
  logic              rnd_inexact;

  // Classify latched operands, pick a special result, and pre-align mantissas so q lands in [1,2).
  always_comb begin
    ca       = fp_classify(a_q);
    cb       = fp_classify(b_q);
    sign_nx  = a_q.sign ^ b_q.sign;
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    spec_res = FP_NANQ;
    if (ca.nan || cb.nan) begin
      spec_inv = ca.snan | cb.snan;
    end else if ((ca.inf && cb.inf) || (ca.zero && cb.zero)) begin
      spec_inv = 1'b1;
    end else if (cb.zero) begin
      spec_dz  = 1'b1;
      spec_res = sign_nx ? FP_INFN : FP_INFP;
    end else if (ca.inf) begin
      spec_res = sign_nx ? FP_INFN : FP_INFP;
    end else if (ca.zero || cb.inf) begin
      spec_res = sign_nx ? FP_ZERON : FP_ZEROP;
    end else begin
      spec_hit = 1'b0;
    end
    ma       = {1'b1, a_q.frac};
    mb       = {1'b1, b_q.frac};
    lt       = (ma < mb);
    rem_init = lt ? {ma, 1'b0} : {1'b0, ma};
    eq_nx    = $signed({2'b00, a_q.exp}) - $signed({2'b00, b_q.exp})
             + (lt ? 10'sd126 : 10'sd127);
  end

  // One restoring step: subtract divisor when it fits, then shift the partial remainder left.
  always_comb begin
    ge       = (rem_q >= {1'b0, dvs_q});
    diff     = rem_q - {1'b0, dvs_q};
    rem_step = ge ? {diff[MW-1:0], 1'b0} : {rem_q[MW-1:0], 1'b0};
  end

  fp_round u_round (
    .sign    (sign_q),
    .exp     (eq_q),
    .q       (q_q),
    .sticky  (rem_q != '0),
    .mode    (rm_q),
    .res     (rnd_res),
    .ov      (rnd_ov),
    .un      (rnd_un),
    .inexact (rnd_inexact)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: specials skip the divide loop, which runs exactly QB iterations.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SPEC;
      S_SPEC:  state_d = spec_hit ? S_ROUND : S_DIV;
      S_DIV:   if (cnt_q == 5'(QB - 1)) state_d = S_ROUND;
      S_ROUND: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // Datapath: latch on accept, prepare in SPEC, iterate in DIV, register result and pulse done in ROUND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      rm_q       <= '0;
      sign_q     <= 1'b0;
      eq_q       <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_inv_q <= 1'b0;
      spec_dz_q  <= 1'b0;
      out        <= '0;
      done       <= 1'b0;
      ov         <= 1'b0;
      un         <= 1'b0;
      inv        <= 1'b0;
      inexact    <= 1'b0;
      dz         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q  <= in1;
            b_q  <= in2;
            rm_q <= round_m;
          end
        end
        S_SPEC: begin
          sign_q     <= sign_nx;
          spec_q     <= spec_hit;
          spec_res_q <= spec_res;
          spec_inv_q <= spec_inv;
          spec_dz_q  <= spec_dz;
          eq_q       <= eq_nx;
          rem_q      <= rem_init;
          dvs_q      <= mb;
          q_q        <= '0;
          cnt_q      <= '0;
        end
        S_DIV: begin
          q_q   <= {q_q[QB-2:0], ge};
          rem_q <= rem_step;
          cnt_q <= cnt_q + 5'd1;
        end
        S_ROUND: begin
          done <= 1'b1;
          if (spec_q) begin
            out     <= spec_res_q;
            ov      <= 1'b0;
            un      <= 1'b0;
            inv     <= spec_inv_q;
            inexact <= 1'b0;
            dz      <= spec_dz_q;
          end else begin
            out     <= rnd_res;
            ov      <= rnd_ov;
            un      <= rnd_un;
            inv     <= 1'b0;
            inexact <= rnd_inexact;
            dz      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Directed self-checking bench for fp_div: arithmetic, rounding, specials, overflow/underflow, handshake.
// Latency: checks done at exactly 2 or 28 edges after accept.
// Backpressure: checks starts during busy are ignored and reset aborts silently.
module tb_fp_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [2:0]  round_m;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        ov;
  logic        un;
  logic        inv;
  logic        inexact;
  logic        dz;

  int n_assert = 0;
  int n_fail   = 0;
  bit seen_done;

  fp_div dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .round_m (round_m),
    .out     (out),
    .busy    (busy),
    .done    (done),
    .ov      (ov),
    .un      (un),
    .inv     (inv),
    .inexact (inexact),
    .dz      (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Flags compared as {ov, un, inv, inexact, dz}.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic [31:0] eo, input logic [4:0] ef,
                       input int elat, input bit poke);
    int lat;
    bit seen;
    @(negedge clk);
    in1 = a; in2 = b; round_m = rm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ":busy_after_accept"}, {31'd0, busy}, 32'd1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      in1 = $urandom;
      in2 = $urandom;
      round_m = 3'($urandom_range(0, 7));
      start = poke && (lat == 4);
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, ":done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, ":latency"}, 32'(lat), 32'(elat));
    check({tag, ":out"}, out, eo);
    check({tag, ":flags"}, {27'd0, ov, un, inv, inexact, dz}, {27'd0, ef});
    check({tag, ":busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, ":done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in1 = '0; in2 = '0; round_m = '0;
    #12;
    check("reset_out", out, 32'd0);
    check("reset_ctl", {30'd0, busy, done}, 32'd0);
    check("reset_flags", {27'd0, ov, un, inv, inexact, dz}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Exact quotient and rounding modes.
    do_op("6div2_rne",  32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 5'b00000, 28, 1'b0);
    do_op("1div3_rne",  32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 5'b00010, 28, 1'b0);
    do_op("1div3_rz",   32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 5'b00010, 28, 1'b0);
    do_op("m1div3_rd",  32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 5'b00010, 28, 1'b0);
    do_op("1div3_ru",   32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 5'b00010, 28, 1'b0);
    do_op("1div3_rsvd", 32'h3F800000, 32'h40400000, 3'b110, 32'h3EAAAAAA, 5'b00010, 28, 1'b0);

    // Special operands.
    do_op("1div0",      32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 5'b00001, 2, 1'b0);
    do_op("m1div0",     32'hBF800000, 32'h00000000, 3'b000, 32'hFF800000, 5'b00001, 2, 1'b0);
    do_op("0div0",      32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 5'b00100, 2, 1'b0);
    do_op("infdivinf",  32'h7F800000, 32'h7F800000, 3'b000, 32'h7FC00000, 5'b00100, 2, 1'b0);
    do_op("qnan",       32'h7FC00000, 32'h3F800000, 3'b000, 32'h7FC00000, 5'b00000, 2, 1'b0);
    do_op("snan",       32'h7FA00000, 32'h3F800000, 3'b000, 32'h7FC00000, 5'b00100, 2, 1'b0);
    do_op("1divinf",    32'hBF800000, 32'h7F800000, 3'b000, 32'h80000000, 5'b00000, 2, 1'b0);

    // Overflow and underflow.
    do_op("ovf_rne",    32'h7F7FFFFF, 32'h3F000000, 3'b000, 32'h7F800000, 5'b10010, 28, 1'b0);
    do_op("ovf_rz",     32'h7F7FFFFF, 32'h3F000000, 3'b001, 32'h7F7FFFFF, 5'b10010, 28, 1'b0);
    do_op("ovf_neg_ru", 32'hFF7FFFFF, 32'h3F000000, 3'b011, 32'hFF7FFFFF, 5'b10010, 28, 1'b0);
    do_op("ovf_neg_rd", 32'hFF7FFFFF, 32'h3F000000, 3'b010, 32'hFF800000, 5'b10010, 28, 1'b0);
    do_op("unf",        32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 5'b01010, 28, 1'b0);

    // Start pulse during DIV must be ignored.
    do_op("poke_busy",  32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 5'b00000, 28, 1'b1);

    // Reset mid-divide aborts without a done pulse.
    @(negedge clk);
    in1 = 32'h3F800000; in2 = 32'h40400000; round_m = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_out", out, 32'd0);
    @(negedge clk); rst = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", {31'd0, seen_done}, 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);

    do_op("after_abort", 32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 5'b00010, 28, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
